// File: rtl/ct_split.sv
// Packet-aware 1:N splitter: routes each input packet to a one-hot or multicast
// subset of outputs, locking the route from first beat to EOP.

module ct_split_lane (
  input  logic cur_sel,
  input  logic done,
  input  logic i_valid,
  input  logic i_ready,
  output logic o_valid,
  output logic lane_ok
);
  // A lane is satisfied once it is unselected, already served, or accepting now.
  assign o_valid = i_valid & cur_sel & ~done;
  assign lane_ok = ~cur_sel | done | i_ready;
endmodule

module ct_split #(
  parameter int RADIX = 2,
  parameter int WIDTH = 1,
  parameter int EOP   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [RADIX-1:0]       i_mask,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [RADIX*WIDTH-1:0] o_data,
  output logic [RADIX-1:0]       o_valid,
  input  logic [RADIX-1:0]       i_ready
);
  typedef enum logic {S_FIRST, S_BODY} state_t;

  state_t           state, state_nxt;
  logic [RADIX-1:0] pkt_mask, pkt_mask_nxt;
  logic [RADIX-1:0] done, done_nxt;
  logic [RADIX-1:0] cur_mask;
  logic [RADIX-1:0] lane_ok;
  logic             transfer;
  logic             eop;

  assign cur_mask = (state == S_BODY) ? pkt_mask : i_mask;
  assign eop      = i_data[EOP];
  assign o_ready  = &lane_ok;
  assign transfer = i_valid & o_ready;
  assign o_data   = {RADIX{i_data}};

  for (genvar k = 0; k < RADIX; k++) begin : g_lane
    ct_split_lane u_lane (
      .cur_sel (cur_mask[k]),
      .done    (done[k]),
      .i_valid (i_valid),
      .i_ready (i_ready[k]),
      .o_valid (o_valid[k]),
      .lane_ok (lane_ok[k])
    );
  end

  always_comb begin
    state_nxt    = state;
    pkt_mask_nxt = pkt_mask;
    // Remember which outputs already took a multicast beat so none sees it twice.
    done_nxt     = transfer ? '0 : (done | (o_valid & i_ready));
    if (transfer) begin
      case (state)
        S_FIRST: if (!eop) begin
          pkt_mask_nxt = i_mask;
          state_nxt    = S_BODY;
        end
        S_BODY:  if (eop) state_nxt = S_FIRST;
        default: state_nxt = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FIRST;
      pkt_mask <= '0;
      done     <= '0;
    end else begin
      state    <= state_nxt;
      pkt_mask <= pkt_mask_nxt;
      done     <= done_nxt;
    end
  end
endmodule

// File: tb/tb_ct_split.sv
// Self-checking bench for ct_split (RADIX=4, 8-bit beats, EOP in bit 0) with a
// per-output scoreboard of expected beats.

module tb_ct_split;
  localparam int RADIX = 4;
  localparam int WIDTH = 8;

  logic                   clk;
  logic                   reset;
  logic [WIDTH-1:0]       i_data;
  logic [RADIX-1:0]       i_mask;
  logic                   i_valid;
  logic                   o_ready;
  logic [RADIX*WIDTH-1:0] o_data;
  logic [RADIX-1:0]       o_valid;
  logic [RADIX-1:0]       i_ready;

  int n_cmp;
  int n_bad;
  logic [6:0]       seq;
  logic [WIDTH-1:0] exp_q [RADIX][$];

  ct_split #(.RADIX(RADIX), .WIDTH(WIDTH), .EOP(0)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_mask  (i_mask),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Every handshake on an output must match the oldest beat expected there.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < RADIX; k++) begin
        if (o_valid[k] && i_ready[k]) begin
          n_cmp++;
          if (exp_q[k].size() == 0) begin
            n_bad++;
            $display("FAIL sb_extra port %0d: got %h, expected no beat", k, o_data[k*WIDTH +: WIDTH]);
          end else begin
            logic [WIDTH-1:0] e;
            e = exp_q[k].pop_front();
            if (o_data[k*WIDTH +: WIDTH] !== e) begin
              n_bad++;
              $display("FAIL sb_data port %0d: got %h, expected %h", k, o_data[k*WIDTH +: WIDTH], e);
            end
          end
        end
      end
    end
  end

  // Present a new beat; pm is the packet's routing mask, m_in what goes on i_mask.
  task automatic present(input logic [RADIX-1:0] pm, input logic [RADIX-1:0] m_in, input bit eop);
    i_valid = 1'b1;
    i_mask  = m_in;
    i_data  = {seq, eop};
    seq     = seq + 7'd1;
    for (int k = 0; k < RADIX; k++)
      if (pm[k]) exp_q[k].push_back(i_data);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_mask  = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; i_valid = 1'b1; i_mask = 4'b0110; i_data = 8'h00; i_ready = 4'b0010;
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 4'b0110) begin n_bad++; $display("FAIL rst_valid: got %b, expected %b", o_valid, 4'b0110); end
    n_cmp++;
    if (o_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_lo: got %b, expected 0", o_ready); end
    i_ready = 4'b0110;
    #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_hi: got %b, expected 1", o_ready); end
    idle();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_unicast();
    i_ready = 4'hF;
    for (int b = 0; b < 3; b++) begin
      present(4'b0100, (b == 0) ? 4'b0100 : 4'b0001, b == 2);
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 4'b0100) begin n_bad++; $display("FAIL uni_valid beat %0d: got %b, expected 0100", b, o_valid); end
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL uni_ready beat %0d: got %b, expected 1", b, o_ready); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_multicast_skew();
    logic [RADIX-1:0] rdy [3];
    logic [RADIX-1:0] ov  [3];
    logic             ordy[3];
    rdy = '{4'b0001, 4'b0010, 4'b1000};
    ov  = '{4'b1011, 4'b1010, 4'b1000};
    ordy = '{1'b0, 1'b0, 1'b1};
    present(4'b1011, 4'b1011, 1'b1);
    for (int c = 0; c < 3; c++) begin
      i_ready = rdy[c];
      @(negedge clk);
      n_cmp++;
      if (o_valid !== ov[c]) begin n_bad++; $display("FAIL mc_valid cyc %0d: got %b, expected %b", c, o_valid, ov[c]); end
      n_cmp++;
      if (o_ready !== ordy[c]) begin n_bad++; $display("FAIL mc_ready cyc %0d: got %b, expected %b", c, o_ready, ordy[c]); end
      @(posedge clk); #1;
    end
    idle(); i_ready = 4'hF;
  endtask

  task automatic test_back_to_back();
    i_ready = 4'hF;
    for (int p = 0; p < 3; p++) begin
      logic [RADIX-1:0] m;
      m = 4'b0001 << p;
      present(m, m, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (o_valid !== m) begin n_bad++; $display("FAIL b2b_valid pkt %0d: got %b, expected %b", p, o_valid, m); end
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready pkt %0d: got %b, expected 1", p, o_ready); end
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic test_zero_mask();
    i_ready = 4'h0;
    for (int b = 0; b < 2; b++) begin
      present(4'b0000, (b == 0) ? 4'b0000 : 4'b0001, b == 1);
      @(negedge clk);
      n_cmp++;
      if (o_valid !== 4'b0000) begin n_bad++; $display("FAIL zm_valid beat %0d: got %b, expected 0000", b, o_valid); end
      n_cmp++;
      if (o_ready !== 1'b1) begin n_bad++; $display("FAIL zm_ready beat %0d: got %b, expected 1", b, o_ready); end
      @(posedge clk); #1;
    end
    i_ready = 4'hF;
    present(4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 4'b0001) begin n_bad++; $display("FAIL zm_next: got %b, expected 0001", o_valid); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset_mid_packet();
    i_ready = 4'hF;
    present(4'b0010, 4'b0010, 1'b0);
    @(posedge clk); #1;
    idle();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    present(4'b0100, 4'b0100, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 4'b0100) begin n_bad++; $display("FAIL rmp_valid: got %b, expected 0100", o_valid); end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random();
    for (int p = 0; p < 200; p++) begin
      int               len;
      logic [RADIX-1:0] m;
      len = $urandom_range(1, 4);
      m   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(negedge clk);
        n_cmp++;
        if (o_valid !== 4'b0000) begin n_bad++; $display("FAIL rnd_idle: got %b, expected 0000", o_valid); end
        @(posedge clk); #1;
      end
      for (int b = 0; b < len; b++) begin
        logic [RADIX-1:0] dl;
        bit               fin;
        int               cnt;
        present(m, (b == 0) ? m : 4'($urandom), b == len - 1);
        dl = '0; fin = 0; cnt = 0;
        while (!fin) begin
          logic [RADIX-1:0] ev;
          logic             er;
          i_ready = 4'($urandom);
          @(negedge clk);
          ev = m & ~dl;
          er = ((dl | i_ready) & m) == m;
          n_cmp++;
          if (o_valid !== ev) begin n_bad++; $display("FAIL rnd_valid pkt %0d: got %b, expected %b", p, o_valid, ev); end
          n_cmp++;
          if (o_ready !== er) begin n_bad++; $display("FAIL rnd_ready pkt %0d: got %b, expected %b", p, o_ready, er); end
          if (er) fin = 1;
          else dl = dl | (ev & i_ready);
          cnt++;
          if (!fin && cnt > 200) begin
            n_bad++; $display("FAIL rnd_timeout pkt %0d: beat not completed, expected completion", p);
            fin = 1;
          end
          @(posedge clk); #1;
        end
      end
    end
    idle(); i_ready = 4'hF;
  endtask

  task automatic test_drain();
    @(negedge clk);
    for (int k = 0; k < RADIX; k++) begin
      n_cmp++;
      if (exp_q[k].size() != 0) begin
        n_bad++; $display("FAIL drain port %0d: %0d beats undelivered, expected 0", k, exp_q[k].size());
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; seq = '0;
    reset = 1'b1; i_valid = 1'b0; i_mask = '0; i_data = '0; i_ready = '0;
    test_reset();
    test_unicast();
    test_multicast_skew();
    test_back_to_back();
    test_zero_mask();
    test_reset_mid_packet();
    test_random();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ct_split.md
# ct_split

Packet-aware 1:N splitter: the fan-out counterpart of the round-robin merge on the same ready/valid packet interface. One input stream is routed to a one-hot or multicast subset of RADIX outputs, selected per packet by a destination mask. Routing is locked from the first beat until the EOP beat, so packets are never interleaved on any output. Multicast beats are held until every selected output has accepted them, with per-output delivery tracking so that no output ever sees a beat twice.

## Interface
- RADIX, 2: number of output ports.
- WIDTH, 1: data width per beat, including the EOP flag bit.
- EOP, 0: bit index within the data word of the end-of-packet flag.

- clk  in  1  single clock; all state on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- i_data  in  WIDTH  input beat.
- i_mask  in  RADIX  destination mask. Sampled only on a packet's first beat; bit k selects output k.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted this cycle; combinational.
- o_data  out  RADIX*WIDTH  slice k (o_data[k*WIDTH +: WIDTH]) equals i_data for every k.
- o_valid  out  RADIX  per-output valid; combinational.
- i_ready  in  RADIX  per-output downstream ready.

## Operation
- States: S_FIRST (next beat starts a packet) and S_BODY (mid-packet). Reset state is S_FIRST.
- Effective mask:
  - cur_mask = i_mask in S_FIRST.
  - cur_mask = pkt_mask (register) in S_BODY; i_mask is ignored there.
- Delivery register done[RADIX]:
  - bit k set means output k already took the current beat.
  - Reset value is 0.
- Per-output valid: o_valid[k] = i_valid & cur_mask[k] & ~done[k].
- Beat completion:
  - o_ready = AND over k of (~cur_mask[k] | done[k] | i_ready[k]).
  - transfer = i_valid & o_ready.
- Update of done:
  - On transfer, done <= 0.
  - Otherwise, done <= done | (o_valid & i_ready).
- Transitions:
  - S_FIRST, transfer, EOP bit = 0: pkt_mask <= i_mask, go to S_BODY.
  - S_FIRST, transfer, EOP bit = 1: stay in S_FIRST (single-beat packet).
  - S_BODY, transfer, EOP bit = 1: go to S_FIRST.
  - All other cases: hold state.
- Zero mask: o_ready = 1 and all o_valid = 0. The beat, and the whole packet, is consumed and dropped, and state still tracks EOP.
- Upstream must hold i_data and i_mask stable while i_valid is high and o_ready is low. Violating this is undefined.
- No data registers: o_data is wired straight from i_data.

## Timing
- Latency is zero cycles. o_valid, o_ready and o_data are combinational from the inputs and from state/done/pkt_mask.
- Combinational paths: o_ready depends on i_ready; o_valid does not depend on i_ready.
- Throughput: one beat per cycle when all selected outputs are ready.
- Partial acceptance: an output that accepts in cycle t has its o_valid low from t+1 until the beat completes. The beat completes in the first cycle where every remaining selected output is ready.
- During reset or immediately after it:
  - done = 0, pkt_mask = 0, state = S_FIRST.
  - o_valid = i_valid & i_mask.
  - o_ready = AND over k of (~i_mask[k] | i_ready[k]).
- Reset mid-packet: the packet is abandoned. The next valid beat is treated as a first beat and uses i_mask.
- Completion and EOP in the same cycle: done clears and the state returns to S_FIRST together. The next cycle samples i_mask for a new packet.

## Test plan
- Unicast: RADIX=4, mask 0100, 3-beat packet (EOP on beat 3), i_ready all 1. Expected:
  - o_valid = 0100 for 3 consecutive cycles and o_ready = 1 each cycle.
  - Changing i_mask to 0001 on beats 2-3 has no effect.
- Multicast skew: mask 1011, single beat.
  - Cycle 0: i_ready = 0001, so o_valid = 1011 and o_ready = 0.
  - Cycle 1: i_ready = 0010, so o_valid = 1010 and o_ready = 0.
  - Cycle 2: i_ready = 1000, so o_valid = 1000 and o_ready = 1.
  - Output 0 never sees the beat twice.
- Back-to-back single-beat packets: masks 0001, 0010, 0100 on consecutive cycles with i_ready all 1. Expected o_valid = 0001, 0010, 0100 and o_ready = 1 on all three cycles.
- Zero mask: mask 0000, 2-beat packet followed by a packet with mask 0001. Expected:
  - o_valid = 0000 and o_ready = 1 for both beats of the first packet.
  - The next packet appears on output 0.
- Reset mid-packet: assert reset after beat 1 of a 4-beat packet with mask 0010, then present a beat with mask 0100 and EOP=1. Expected o_valid = 0100.
- Randomized backpressure: i_ready toggled randomly, 200 packets with random masks. Scoreboard checks each selected output receives every beat exactly once, in order, with no interleaving between packets.
